// File: rtl/csa_final_adder_seq_if.sv
// Handshake bundle between the CSA array, the final carry-propagate stage and
// its consumer.
interface csa_final_adder_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] result;

    modport master (
        output in_valid, s_in, c_in, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, s_in, c_in, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/csa_final_adder_seq.sv
// Sequential final adder for a carry-save pair: result = S + 2*C, resolved
// CHUNK bits per cycle with a registered ripple carry.
module csa_final_adder_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    csa_final_adder_seq_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned NP     = 2 ** CW;
    localparam int unsigned LOW_W  = NP * CHUNK;

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("csa_final_adder_seq: CHUNK must be in 1..WIDTH and divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state_q, state_d;

    // Operands held as chunk arrays indexed by cnt; sreg's top bit is always
    // zero and creg's top bit is kept separately, so neither needs a slot.
    logic [NP-1:0][CHUNK-1:0] s_lo_q, s_lo_d;
    logic [NP-1:0][CHUNK-1:0] c_lo_q, c_lo_d;
    logic                     c_top_q, c_top_d;
    logic [NP-1:0][CHUNK-1:0] res_lo_q, res_lo_d;
    logic [1:0]               res_hi_q, res_hi_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     carry_q, carry_d;

    logic [CHUNK:0]           chunk_sum;
    logic                     accept;
    logic                     last;
    logic [LOW_W-1:0]         res_flat;

    assign accept   = bus.in_valid && (state_q == IDLE);
    assign last     = (cnt_q == CW'(NCHUNK - 1));
    assign res_flat = res_lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = BUSY;
            BUSY:    if (last)         state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    assign bus.result = {res_hi_q, res_flat[WIDTH-1:0]};

    always_comb begin
        s_lo_d    = s_lo_q;
        c_lo_d    = c_lo_q;
        c_top_d   = c_top_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        chunk_sum = {{CHUNK{1'b0}}, carry_q}
                  + {1'b0, s_lo_q[cnt_q]}
                  + {1'b0, c_lo_q[cnt_q]};
        if (accept) begin
            s_lo_d  = LOW_W'(bus.s_in);
            c_lo_d  = LOW_W'({bus.c_in, 1'b0});
            c_top_d = bus.c_in[WIDTH-1];
            cnt_d   = '0;
            carry_d = 1'b0;
        end else if (state_q == BUSY) begin
            res_lo_d[cnt_q] = chunk_sum[CHUNK-1:0];
            carry_d         = chunk_sum[CHUNK];
            cnt_d           = cnt_q + CW'(1);
            // creg[WIDTH] plus the final carry-out forms the two top bits.
            if (last) begin
                res_hi_d = {1'b0, c_top_q} + {1'b0, chunk_sum[CHUNK]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_lo_q   <= '0;
            c_lo_q   <= '0;
            c_top_q  <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            s_lo_q   <= s_lo_d;
            c_lo_q   <= c_lo_d;
            c_top_q  <= c_top_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
        end
    end
endmodule

// File: tb/tb_csa_final_adder_seq.sv
// Bench for csa_final_adder_seq: four instances (CHUNK = 4, 1, 8, 16) checked
// against S + 2*C with directed corner cases and randomized stalls.
module tb_csa_final_adder_seq;
    localparam int unsigned W = 16;
    localparam int unsigned CHS [4] = '{4, 1, 8, 16};
    localparam int unsigned BUDGET = 200;

    logic             clk;
    logic             rst_n;
    logic [W-1:0]     s_in;
    logic [W-1:0]     c_in;
    logic [3:0]       in_valid_v;
    logic [3:0]       out_ready_v;
    logic [3:0]       in_ready_v;
    logic [3:0]       out_valid_v;
    logic [W+1:0]     result_v [4];

    int unsigned n_vec;
    int unsigned n_err;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        csa_final_adder_seq_if #(.WIDTH(W)) bus ();

        csa_final_adder_seq #(.WIDTH(W), .CHUNK(CHS[g])) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.in_valid  = in_valid_v[g];
        assign bus.s_in      = s_in;
        assign bus.c_in      = c_in;
        assign bus.out_ready = out_ready_v[g];
        assign in_ready_v[g]  = bus.in_ready;
        assign out_valid_v[g] = bus.out_valid;
        assign result_v[g]    = bus.result;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W+1:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
        return {2'b00, s} + ({2'b00, c} << 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation on the instances in mask; latency, result stability and
    // in_ready are checked each cycle until every instance has handed off.
    task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] c,
                          input logic [3:0] mask, input bit stall);
        logic [W+1:0] exp;
        logic [3:0]   done;
        logic [3:0]   seen;
        int unsigned  j;
        exp = model(s, c);
        @(posedge clk); #1;
        s_in = s;
        c_in = c;
        in_valid_v = mask;
        check_eq("in_ready_idle", 32'(in_ready_v & mask), 32'(mask));
        @(posedge clk); #1;
        in_valid_v = '0;
        s_in = W'($urandom);
        c_in = W'($urandom);
        done = ~mask;
        seen = ~mask;
        j = 0;
        while ((done != 4'hF) && (j <= BUDGET)) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                if (!done[g]) begin
                    out_ready_v[g] = stall ? ($urandom_range(3) != 0) : 1'b1;
                    check_eq("in_ready_busy", 32'(in_ready_v[g]), 32'd0);
                    if (out_valid_v[g]) begin
                        if (!seen[g]) begin
                            check_eq("latency", 32'(j), 32'(W / CHS[g]));
                            seen[g] = 1'b1;
                        end
                        check_eq("result", 32'(result_v[g]), 32'(exp));
                        if (out_ready_v[g]) done[g] = 1'b1;
                    end
                end
            end
            j++;
        end
        if (done != 4'hF) check_eq("timeout", 32'(done), 32'hF);
    endtask

    task automatic backpressure_test();
        logic [W+1:0] exp1;
        logic [W+1:0] exp2;
        exp1 = model(16'hABCD, 16'h1234);
        exp2 = model(16'h0F0F, 16'h00F0);
        @(posedge clk); #1;
        s_in = 16'hABCD;
        c_in = 16'h1234;
        in_valid_v = 4'b0001;
        out_ready_v = 4'b1110;
        @(posedge clk); #1;
        s_in = 16'h0F0F;
        c_in = 16'h00F0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("bp_early_valid", 32'(out_valid_v[0]), 32'd0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(out_valid_v[0]), 32'd1);
            check_eq("bp_in_ready", 32'(in_ready_v[0]), 32'd0);
            check_eq("bp_result", 32'(result_v[0]), 32'(exp1));
        end
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_idle_ready", 32'(in_ready_v[0]), 32'd1);
        check_eq("bp_idle_valid", 32'(out_valid_v[0]), 32'd0);
        check_eq("bp_idle_result", 32'(result_v[0]), 32'(exp1));
        @(posedge clk); #1;
        in_valid_v = '0;
        check_eq("bp_queued_accept", 32'(in_ready_v[0]), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("bp2_valid", 32'(out_valid_v[0]), 32'd1);
        check_eq("bp2_result", 32'(result_v[0]), 32'(exp2));
    endtask

    task automatic mid_reset_test();
        @(posedge clk); #1;
        s_in = 16'h1234;
        c_in = 16'h0F0F;
        in_valid_v = 4'b0011;
        out_ready_v = '0;
        @(posedge clk); #1;
        in_valid_v = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            check_eq("mrst_in_ready", 32'(in_ready_v[g]), 32'd1);
            check_eq("mrst_out_valid", 32'(out_valid_v[g]), 32'd0);
            check_eq("mrst_result", 32'(result_v[g]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check_eq("mrst_no_output", 32'(out_valid_v), 32'd0);
        end
        out_ready_v = '1;
        run_op(16'h1234, 16'h0F0F, 4'hF, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        s_in = '0;
        c_in = '0;
        in_valid_v = '0;
        out_ready_v = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            check_eq("rst_in_ready", 32'(in_ready_v[g]), 32'd1);
            check_eq("rst_out_valid", 32'(out_valid_v[g]), 32'd0);
            check_eq("rst_result", 32'(result_v[g]), 32'd0);
        end
        rst_n = 1'b1;

        run_op(16'h0001, 16'h7FFF, 4'hF, 1'b0);
        run_op(16'hFFFF, 16'h0000, 4'hF, 1'b0);
        run_op(16'h0002, 16'h7FFF, 4'hF, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 4'hF, 1'b0);
        run_op(16'h0000, 16'h8000, 4'hF, 1'b0);
        run_op(16'h0000, 16'h0000, 4'hF, 1'b0);

        backpressure_test();
        mid_reset_test();

        for (int n = 0; n < 1000; n++) begin
            run_op(W'($urandom), W'($urandom), 4'hF, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached, got %0d miscompares so far, expected completion", n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
